aes_key_schedule: RTL and testbench
===================================

# aes_key_schedule

Sequential AES-128 key expansion that feeds the combinational cipher round with one 128-bit round key per handshake. After a `start`, the block emits round keys 0 (the cipher key itself) through 10, in order, on a valid/ready stream. It computes each next key from the current one, so no 11-entry key table is stored. It sits directly upstream of the round datapath's `cipher_key` input and is paced by the round controller through `round_key_ready`.

## Interface
- (no parameters) — fixed AES-128: Nk=4, Nr=10, 11 round keys.
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `start`  in  1  — request a new expansion; accepted only when `ready`=1.
- `key_in`  in  128  — cipher key, sampled only in the cycle `start` is accepted. `key_in[127:120]` is key byte 0; w0 = `key_in[127:96]`.
- `ready`  out  1  — block idle, can accept `start`.
- `round_key`  out  128  — current round key {w[4i], w[4i+1], w[4i+2], w[4i+3]}, same byte order as `key_in`.
- `round_key_valid`  out  1  — `round_key` and `round_idx` are valid.
- `round_key_ready`  in  1  — consumer accepts the current key this cycle.
- `round_idx`  out  4  — index 0..10 of the key on `round_key`.
- `done`  out  1  — one-cycle pulse after key 10 is accepted.

## Operation
- Reset values: `round_key`=0, `round_key_valid`=0, `round_idx`=0, `done`=0, `ready`=1. The FSM resets to IDLE.
- FSM states:
  - IDLE: `ready`=1. On `start`, register `key_in` into `round_key`, set `round_idx`=0, set `round_key_valid`=1, and go to RUN.
  - RUN: `ready`=0. A handshake occurs when `round_key_valid` and `round_key_ready` are both 1.
    - Handshake with `round_idx`<10: register the next key and increment `round_idx`. `round_key_valid` stays 1.
    - Handshake with `round_idx`=10: clear `round_key_valid`, pulse `done`, return to IDLE. `round_key` holds key 10 and `round_idx` holds 10 until the next `start`.
- Next-key computation (combinational from the registered key, registered on handshake):
  - temp = SubWord(RotWord(w3)) ^ {rcon, 24'h0}.
  - w0' = w0^temp; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - RotWord rotates bytes left by one: {b0,b1,b2,b3} -> {b1,b2,b3,b0}.
  - SubWord applies the standard AES S-box to each of the 4 bytes (4 S-box instances).
- rcon when producing key k (k=1..10): 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36. rcon is derived from `round_idx` (a case lookup), not stored separately.
- Stream rules:
  - While `round_key_valid`=1 and `round_key_ready`=0, `round_key` and `round_idx` are held stable.
  - `round_key_valid` never drops mid-expansion.
- Boundary conditions:
  - `start` while `ready`=0 is ignored; `key_in` changes are ignored outside an accepted start.
  - `start` in the same cycle as `done` is accepted, since `ready`=1 in the `done` cycle.
  - `rst` asserted mid-expansion immediately forces all reset values and IDLE. The next `start` after `rst` deasserts begins a fresh expansion.
  - `round_key_ready` held high while in IDLE has no effect.

## Timing
- `start` accepted at edge t -> key 0 is valid after edge t (cycle t+1).
- With `round_key_ready` held at 1, key k is visible in cycle t+1+k; key 10 appears in cycle t+11.
- `done`=1 and `ready`=1 in cycle t+12, so back-to-back expansions take 12 cycles each.
- Each cycle of `round_key_ready`=0 during RUN adds one cycle of latency to all remaining keys and to `done`.
- Single-cycle combinational path: 4 S-boxes plus a 4-deep XOR chain, registered at the handshake.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, `round_key_ready`=1 -> keys appear in consecutive cycles:
  - idx0 = 2b7e151628aed2a6abf7158809cf4f3c
  - idx1 = a0fafe1788542cb123a339392a6c7605
  - idx2 = f2c295f27a96b9435935807a7359f67f
  - idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6
  - `done` pulses 12 cycles after the start edge.
- All-zero key -> idx1 = 62636363626363636263636362636363 and idx10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- FIPS key with `round_key_ready` randomly toggled, including 5 consecutive low cycles at idx4 -> same 11 keys in the same order, each held stable while stalled, exactly 11 handshakes, one `done`.
- `start` pulsed at idx3 with key 000102...0f -> ignored; the FIPS sequence completes unchanged.
- `rst` pulsed at idx6 -> all outputs go to their reset values immediately. A following all-zero-key `start` then yields idx0 = 0 and idx1 = 6263...63.
- `start` asserted in the `done` cycle with the zero key -> accepted; key 0 = 0 is valid in the next cycle.

Source files
------------

// File: rtl/aes_key_schedule_if.sv
// rtl/aes_key_schedule_if.sv - start request and round-key stream bundle of the AES-128 key schedule
//
// Purpose: groups the request side (start/key_in/ready), the round-key stream
// (round_key/round_key_valid/round_key_ready/round_idx) and the done pulse.
// Ports (seen from the key schedule, modport slave):
//   start           in   1   request a new expansion
//   key_in          in   128 cipher key, byte 0 in [127:120]
//   ready           out  1   idle, start will be accepted
//   round_key       out  128 current round key
//   round_key_valid out  1   round_key/round_idx valid
//   round_key_ready in   1   consumer takes the key this cycle
//   round_idx       out  4   index 0..10 of round_key
//   done            out  1   pulse after key 10 is taken
// modport master is the mirror image used by the upstream/consumer side.
interface aes_key_schedule_if;
  logic         start;
  logic [127:0] key_in;
  logic         ready;
  logic [127:0] round_key;
  logic         round_key_valid;
  logic         round_key_ready;
  logic [3:0]   round_idx;
  logic         done;

  modport master (
    output start, key_in, round_key_ready,
    input  ready, round_key, round_key_valid, round_idx, done
  );

  modport slave (
    input  start, key_in, round_key_ready,
    output ready, round_key, round_key_valid, round_idx, done
  );
endinterface

// File: rtl/aes_key_schedule.sv
// rtl/aes_key_schedule.sv - sequential AES-128 key expansion emitting 11 round keys on a valid/ready stream
//
// Purpose: after an accepted start, presents round keys 0..10 one per
// handshake. Only the current key is stored; the next key is derived from it
// combinationally and registered on each handshake.
// Ports:
//   clk  in  1  rising-edge clock
//   rst  in  1  asynchronous active-high reset
//   ks   aes_key_schedule_if.slave  request, round-key stream and done pulse
module aes_key_schedule (
  input  logic              clk,
  input  logic              rst,
  aes_key_schedule_if.slave ks
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [127:0] round_key_q, round_key_d;
  logic [3:0]   round_idx_q, round_idx_d;
  logic         valid_q, valid_d;
  logic         done_q, done_d;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot_w3, sub_w3, temp;
  logic [31:0]  n0, n1, n2, n3;
  logic [7:0]   rcon;
  logic         handshake;

  assign w0 = round_key_q[127:96];
  assign w1 = round_key_q[95:64];
  assign w2 = round_key_q[63:32];
  assign w3 = round_key_q[31:0];

  assign rot_w3 = {w3[23:0], w3[31:24]};
  assign sub_w3 = {SBOX[rot_w3[31:24]], SBOX[rot_w3[23:16]],
                   SBOX[rot_w3[15:8]],  SBOX[rot_w3[7:0]]};

  // round_idx_q is the index of the key being consumed, so the constant
  // belongs to key round_idx_q+1.
  always_comb begin
    rcon = 8'h00;
    case (round_idx_q)
      4'd0:    rcon = 8'h01;
      4'd1:    rcon = 8'h02;
      4'd2:    rcon = 8'h04;
      4'd3:    rcon = 8'h08;
      4'd4:    rcon = 8'h10;
      4'd5:    rcon = 8'h20;
      4'd6:    rcon = 8'h40;
      4'd7:    rcon = 8'h80;
      4'd8:    rcon = 8'h1b;
      4'd9:    rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign temp = sub_w3 ^ {rcon, 24'h000000};
  assign n0   = w0 ^ temp;
  assign n1   = w1 ^ n0;
  assign n2   = w2 ^ n1;
  assign n3   = w3 ^ n2;

  assign handshake = valid_q && ks.round_key_ready;

  always_comb begin
    state_d     = state_q;
    round_key_d = round_key_q;
    round_idx_d = round_idx_q;
    valid_d     = valid_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (ks.start) begin
          round_key_d = ks.key_in;
          round_idx_d = 4'd0;
          valid_d     = 1'b1;
          state_d     = RUN;
        end
      end
      RUN: begin
        if (handshake) begin
          if (round_idx_q == 4'd10) begin
            // key 10 and its index stay visible until the next start
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            round_key_d = {n0, n1, n2, n3};
            round_idx_d = round_idx_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      round_key_q <= '0;
      round_idx_q <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_key_q <= round_key_d;
      round_idx_q <= round_idx_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
    end
  end

  // ready is high in the done cycle too, which allows back-to-back starts
  assign ks.ready           = (state_q == IDLE);
  assign ks.round_key       = round_key_q;
  assign ks.round_key_valid = valid_q;
  assign ks.round_idx       = round_idx_q;
  assign ks.done            = done_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// tb/tb_aes_key_schedule.sv - self-checking bench for aes_key_schedule
module tb_aes_key_schedule;

  logic clk;
  logic rst;

  aes_key_schedule_if bus ();

  aes_key_schedule dut (
    .clk (clk),
    .rst (rst),
    .ks  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
    bit           chk;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic [127:0] fips_keys [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  task automatic push_fips();
    for (int i = 0; i < 11; i++) sb.push_back('{idx: 4'(i), key: fips_keys[i], chk: 1'b1});
  endtask

  // Zero key: only the values published for it are checked; all indices are.
  task automatic push_zero();
    for (int i = 0; i < 11; i++) begin
      exp_t e;
      e.idx = 4'(i);
      e.chk = 1'b0;
      e.key = '0;
      if (i == 0) e.chk = 1'b1;
      if (i == 1) begin e.key = 128'h62636363626363636263636362636363; e.chk = 1'b1; end
      if (i == 10) begin e.key = 128'hb4ef5bcb3e92e21123e951cf6f8f188e; e.chk = 1'b1; end
      sb.push_back(e);
    end
  endtask

  // Called at a negedge; returns at the negedge of the key-0 cycle.
  task automatic start_exp(input string name, input logic [127:0] key);
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_before_start: got %b want 1", name, bus.ready);
    end
    bus.start  = 1'b1;
    bus.key_in = key;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.key_in = {$urandom, $urandom, $urandom, $urandom};
    checks++;
    if (bus.round_key_valid !== 1'b1 || bus.round_idx !== 4'd0 || bus.round_key !== key) begin
      errors++;
      $display("FAIL %s_key0: got v=%b idx=%0d key=%h want v=1 idx=0 key=%h",
               name, bus.round_key_valid, bus.round_idx, bus.round_key, key);
    end
  endtask

  // Consumes the stream against the scoreboard. cyc 0 is the key-0 cycle.
  task automatic run_keys(input string name, input bit rand_stall, input int start_at,
                          input int rst_at, output int hs, output int done_cyc, output int stalls);
    int           cyc;
    bit           fin, injected, forced, have_prev, prev_valid, prev_rdy, rdy;
    int           stall_left;
    logic [127:0] prev_key;
    logic [3:0]   prev_idx;
    exp_t         e;
    hs = 0; done_cyc = -1; stalls = 0; cyc = 0; fin = 0; injected = 0; forced = 0;
    have_prev = 0; prev_valid = 0; prev_rdy = 0; stall_left = 0; prev_key = '0; prev_idx = '0;
    while (!fin && cyc < 300) begin
      bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        done_cyc = cyc;
        fin = 1;
        checks++;
        if (bus.round_key_valid !== 1'b0 || bus.ready !== 1'b1) begin
          errors++;
          $display("FAIL %s_done_cycle: got v=%b ready=%b want v=0 ready=1",
                   name, bus.round_key_valid, bus.ready);
        end
      end else if (rst_at >= 0 && bus.round_key_valid === 1'b1 && bus.round_idx == rst_at[3:0]) begin
        bus.round_key_ready = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.round_key_valid !== 1'b0 || bus.round_idx !== 4'd0 || bus.round_key !== 128'd0 ||
            bus.done !== 1'b0 || bus.ready !== 1'b1) begin
          errors++;
          $display("FAIL %s_async_reset: got v=%b idx=%0d key=%h done=%b ready=%b want 0 0 0 0 1",
                   name, bus.round_key_valid, bus.round_idx, bus.round_key, bus.done, bus.ready);
        end
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        fin = 1;
      end else begin
        if (have_prev && prev_valid) begin
          checks++;
          if (bus.round_key_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_valid_held: got %b want 1 at cycle %0d", name, bus.round_key_valid, cyc);
          end
        end
        if (have_prev && prev_valid && !prev_rdy) begin
          checks++;
          if (bus.round_key !== prev_key || bus.round_idx !== prev_idx) begin
            errors++;
            $display("FAIL %s_stall_stable: got idx=%0d key=%h want idx=%0d key=%h",
                     name, bus.round_idx, bus.round_key, prev_idx, prev_key);
          end
        end
        if (start_at >= 0 && !injected && bus.round_key_valid === 1'b1 && bus.round_idx == start_at[3:0]) begin
          bus.start  = 1'b1;
          bus.key_in = 128'h000102030405060708090a0b0c0d0e0f;
          injected   = 1;
        end
        rdy = 1'b1;
        if (rand_stall) begin
          if (!forced && bus.round_key_valid === 1'b1 && bus.round_idx == 4'd4) begin
            stall_left = 5;
            forced = 1;
          end
          if (stall_left > 0) begin
            rdy = 1'b0;
            stall_left--;
          end else begin
            rdy = 1'($urandom_range(0, 1));
          end
        end
        bus.round_key_ready = rdy;
        if (bus.round_key_valid === 1'b1 && !rdy) stalls++;
        if (bus.round_key_valid === 1'b1 && rdy) begin
          hs++;
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s_unexpected_key: got idx=%0d with empty scoreboard", name, bus.round_idx);
          end else begin
            e = sb.pop_front();
            if (bus.round_idx !== e.idx || (e.chk && bus.round_key !== e.key)) begin
              errors++;
              $display("FAIL %s_key: got idx=%0d key=%h want idx=%0d key=%h",
                       name, bus.round_idx, bus.round_key, e.idx, e.key);
            end
          end
        end
        have_prev  = 1;
        prev_valid = bus.round_key_valid;
        prev_rdy   = rdy;
        prev_key   = bus.round_key;
        prev_idx   = bus.round_idx;
        @(negedge clk);
        cyc++;
      end
    end
    bus.start = 1'b0;
    bus.round_key_ready = 1'b0;
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no done within %0d cycles", name, cyc);
    end
  endtask

  task automatic check_end(input string name, input int hs, input int done_cyc, input int want_done);
    checks++;
    if (hs != 11 || sb.size() != 0) begin
      errors++;
      $display("FAIL %s_handshakes: got %0d (left %0d) want 11 (left 0)", name, hs, sb.size());
    end
    checks++;
    if (done_cyc != want_done) begin
      errors++;
      $display("FAIL %s_done_latency: got %0d want %0d", name, done_cyc, want_done);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.round_key !== 128'd0 || bus.round_key_valid !== 1'b0 || bus.round_idx !== 4'd0 ||
        bus.done !== 1'b0 || bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_values: got key=%h v=%b idx=%0d done=%b ready=%b want 0 0 0 0 1",
               bus.round_key, bus.round_key_valid, bus.round_idx, bus.done, bus.ready);
    end
  endtask

  task automatic test_idle_ready();
    bus.round_key_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.round_key_valid !== 1'b0 || bus.ready !== 1'b1 || bus.done !== 1'b0 ||
          bus.round_key !== 128'd0 || bus.round_idx !== 4'd0) begin
        errors++;
        $display("FAIL idle_ready: got v=%b ready=%b done=%b idx=%0d want 0 1 0 0",
                 bus.round_key_valid, bus.ready, bus.done, bus.round_idx);
      end
    end
    bus.round_key_ready = 1'b0;
  endtask

  task automatic test_fips_stream();
    int hs, dc, st;
    push_fips();
    start_exp("fips", FIPS_KEY);
    run_keys("fips", 1'b0, -1, -1, hs, dc, st);
    check_end("fips", hs, dc, 11);
  endtask

  task automatic test_zero_key();
    int hs, dc, st;
    @(negedge clk);
    push_zero();
    start_exp("zero", 128'd0);
    run_keys("zero", 1'b0, -1, -1, hs, dc, st);
    check_end("zero", hs, dc, 11);
  endtask

  task automatic test_random_stall();
    int hs, dc, st;
    @(negedge clk);
    push_fips();
    start_exp("stall", FIPS_KEY);
    run_keys("stall", 1'b1, -1, -1, hs, dc, st);
    check_end("stall", hs, dc, 11 + st);
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL stall_single_done: got %b want 0", bus.done);
    end
  endtask

  task automatic test_start_ignored();
    int hs, dc, st;
    @(negedge clk);
    push_fips();
    start_exp("ignored", FIPS_KEY);
    run_keys("ignored", 1'b0, 3, -1, hs, dc, st);
    check_end("ignored", hs, dc, 11);
  endtask

  task automatic test_rst_mid();
    int hs, dc, st;
    @(negedge clk);
    push_fips();
    start_exp("rstmid", FIPS_KEY);
    run_keys("rstmid", 1'b0, -1, 6, hs, dc, st);
    checks++;
    if (dc != -1 || hs != 6) begin
      errors++;
      $display("FAIL rstmid_abort: got done_cyc=%0d hs=%0d want -1 6", dc, hs);
    end
    push_zero();
    start_exp("after_rst", 128'd0);
    run_keys("after_rst", 1'b0, -1, -1, hs, dc, st);
    check_end("after_rst", hs, dc, 11);
  endtask

  task automatic test_back_to_back();
    int hs, dc, st;
    @(negedge clk);
    push_fips();
    start_exp("b2b_first", FIPS_KEY);
    run_keys("b2b_first", 1'b0, -1, -1, hs, dc, st);
    check_end("b2b_first", hs, dc, 11);
    push_zero();
    start_exp("b2b_second", 128'd0);
    run_keys("b2b_second", 1'b0, -1, -1, hs, dc, st);
    check_end("b2b_second", hs, dc, 11);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.key_in = '0;
    bus.round_key_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_idle_ready();
    test_fips_stream();
    test_zero_key();
    test_random_stall();
    test_start_ignored();
    test_rst_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
